// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Brief    : Shared constants and types for the buffered 1-to-3 demultiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package demux_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int NUM_CH    = 3;

   localparam logic [1:0] SEL_CH0  = 2'b00;
   localparam logic [1:0] SEL_CH1  = 2'b01;
   localparam logic [1:0] SEL_CH2  = 2'b10;
   localparam logic [1:0] SEL_DROP = 2'b11;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } chan_state_e;

endpackage
`default_nettype wire

// File: rtl/chan_fifo.sv
`default_nettype none
// ============================================================================
// Module   : chan_fifo
// Brief    : Per-channel synchronous FIFO; head word is always on dout.
// Revision : 1.0 - initial release
// ============================================================================
module chan_fifo
   import demux_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   chan_state_e        r_state;

   logic               w_push;
   logic               w_pop;
   logic [c_CNT_W-1:0] w_count_nxt;
   chan_state_e        w_state_nxt;

   // Guard against protocol misuse so pointers never run past one another.
   assign w_push = push && (r_state != ST_FULL);
   assign w_pop  = pop  && (r_state != ST_EMPTY);

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase

      w_state_nxt = ST_PARTIAL;
      if (w_count_nxt == '0)
         w_state_nxt = ST_EMPTY;
      else if (w_count_nxt == c_CNT_W'(DEPTH))
         w_state_nxt = ST_FULL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_state  <= ST_EMPTY;
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
         r_state <= w_state_nxt;
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign empty = (r_state == ST_EMPTY);
   assign full  = (r_state == ST_FULL);

endmodule
`default_nettype wire

// File: rtl/demux3_fifo.sv
`default_nettype none
// ============================================================================
// Module   : demux3_fifo
// Brief    : Buffered 1-to-3 demultiplexer with per-channel FIFOs and a
//            saturating drop counter for the discard select.
// Revision : 1.0 - initial release
// ============================================================================
module demux3_fifo
   import demux_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  in_data,
   input  logic [1:0]        in_sel,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WIDTH-1:0]  out_data0,
   output logic [WIDTH-1:0]  out_data1,
   output logic [WIDTH-1:0]  out_data2,
   output logic [NUM_CH-1:0] out_valid,
   input  logic [NUM_CH-1:0] out_ready,
   output logic [CNT_W-1:0]  drop_cnt
);

   localparam logic [CNT_W-1:0] c_DROP_MAX = {CNT_W{1'b1}};

   logic [NUM_CH-1:0] w_push;
   logic [NUM_CH-1:0] w_pop;
   logic [NUM_CH-1:0] w_empty;
   logic [NUM_CH-1:0] w_full;
   logic [WIDTH-1:0]  w_dout [NUM_CH];
   logic              w_drop;
   logic              w_in_ready;
   logic [CNT_W-1:0]  r_drop_cnt;

   // Ready depends only on the selected channel's fullness, never on in_valid.
   always_comb begin
      w_push     = '0;
      w_drop     = 1'b0;
      w_in_ready = 1'b1;
      case (in_sel)
         SEL_CH0: begin
            w_in_ready = !w_full[0];
            w_push[0]  = in_valid && !w_full[0];
         end
         SEL_CH1: begin
            w_in_ready = !w_full[1];
            w_push[1]  = in_valid && !w_full[1];
         end
         SEL_CH2: begin
            w_in_ready = !w_full[2];
            w_push[2]  = in_valid && !w_full[2];
         end
         SEL_DROP: begin
            w_in_ready = 1'b1;
            w_drop     = in_valid;
         end
         default: begin
            w_in_ready = 1'b1;
         end
      endcase
   end

   assign w_pop = ~w_empty & out_ready;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      chan_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (w_push[i]),
         .pop   (w_pop[i]),
         .din   (in_data),
         .dout  (w_dout[i]),
         .empty (w_empty[i]),
         .full  (w_full[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_drop_cnt <= '0;
      else if (w_drop && (r_drop_cnt != c_DROP_MAX))
         r_drop_cnt <= r_drop_cnt + 1'b1;
   end

   assign in_ready  = w_in_ready;
   assign out_valid = ~w_empty;
   assign out_data0 = w_dout[0];
   assign out_data1 = w_dout[1];
   assign out_data2 = w_dout[2];
   assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux3_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux3_fifo
// Brief    : Directed self-checking bench for demux3_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux3_fifo;

   logic        clk;
   logic        rst_n;
   logic [15:0] in_data;
   logic [1:0]  in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data0;
   logic [15:0] out_data1;
   logic [15:0] out_data2;
   logic [2:0]  out_valid;
   logic [2:0]  out_ready;
   logic [7:0]  drop_cnt;

   int n_cmp = 0;
   int n_err = 0;

   demux3_fifo #(
      .WIDTH (16),
      .DEPTH (2),
      .CNT_W (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .drop_cnt  (drop_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] q[$];
   logic [15:0] nxt;
   logic        exp_rdy;

   initial begin
      rst_n     = 1'b0;
      in_data   = '0;
      in_sel    = 2'b00;
      in_valid  = 1'b0;
      out_ready = 3'b000;
      #12;
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
      check("rst_out_data0", 32'(out_data0), 32'h0);
      check("rst_out_data2", 32'(out_data2), 32'h0);
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1;
         check("rst_in_ready", 32'(in_ready), 32'h1);
      end
      rst_n = 1'b1;
      tick();

      // Single word to ch1
      in_sel = 2'b01; in_data = 16'hA5A5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
      check("t1_out_valid", 32'(out_valid), 32'h2);
      check("t1_out_data1", 32'(out_data1), 32'hA5A5);
      check("t1_drop_cnt", 32'(drop_cnt), 32'h0);
      out_ready = 3'b010;
      tick();
      out_ready = 3'b000;
      check("t1_drained", 32'(out_valid), 32'h0);

      // Fill ch0, check per-select backpressure, then drain in order
      in_sel = 2'b00; in_data = 16'h0001; in_valid = 1'b1;
      tick();
      in_data = 16'h0002;
      tick();
      in_valid = 1'b0;
      #1;
      check("t2_out_valid", 32'(out_valid), 32'h1);
      check("t2_ready_sel0", 32'(in_ready), 32'h0);
      in_sel = 2'b01;
      #1;
      check("t2_ready_sel1", 32'(in_ready), 32'h1);
      check("t2_head0", 32'(out_data0), 32'h0001);
      out_ready = 3'b001;
      tick();
      check("t2_head1", 32'(out_data0), 32'h0002);
      tick();
      out_ready = 3'b000;
      check("t2_empty", 32'(out_valid), 32'h0);

      // Ch0 full and stalled while ch2 streams at full rate
      in_sel = 2'b00; in_data = 16'h0011; in_valid = 1'b1;
      tick();
      in_data = 16'h0022;
      tick();
      out_ready = 3'b100;
      in_sel = 2'b10;
      for (int k = 0; k < 4; k++) begin
         in_data = 16'hC001 + 16'(k);
         #1;
         check("t3_ready_ch2", 32'(in_ready), 32'h1);
         tick();
         check("t3_out_valid2", 32'(out_valid[2]), 32'h1);
         check("t3_data2", 32'(out_data2), 32'(16'hC001 + 16'(k)));
      end
      in_valid = 1'b0;
      tick();
      check("t3_ch2_drained", 32'(out_valid[2]), 32'h0);
      check("t3_ch0_valid", 32'(out_valid[0]), 32'h1);
      check("t3_ch0_head", 32'(out_data0), 32'h0011);
      out_ready = 3'b001;
      tick();
      check("t3_ch0_second", 32'(out_data0), 32'h0022);
      tick();
      out_ready = 3'b000;
      check("t3_all_empty", 32'(out_valid), 32'h0);

      // Ch1 full, continuous push + pop with scoreboard
      q.delete();
      in_sel = 2'b01; in_valid = 1'b1;
      in_data = 16'hB000;
      tick();
      q.push_back(16'hB000);
      in_data = 16'hB001;
      tick();
      q.push_back(16'hB001);
      nxt = 16'hB002;
      out_ready = 3'b010;
      for (int k = 0; k < 10; k++) begin
         in_data = nxt;
         #1;
         exp_rdy = (q.size() < 2);
         check("t4_in_ready", 32'(in_ready), 32'(exp_rdy));
         check("t4_out_valid1", 32'(out_valid[1]), 32'(q.size() > 0));
         if (q.size() > 0) begin
            check("t4_data1", 32'(out_data1), 32'(q[0]));
            void'(q.pop_front());
         end
         if (exp_rdy) begin
            q.push_back(nxt);
            nxt = nxt + 16'h1;
         end
         tick();
      end
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("t4_drain_valid", 32'(out_valid[1]), 32'(q.size() > 0));
         if (q.size() > 0) begin
            check("t4_drain_data", 32'(out_data1), 32'(q[0]));
            void'(q.pop_front());
         end
         tick();
      end
      out_ready = 3'b000;
      check("t4_empty", 32'(out_valid), 32'h0);

      // Drop counter saturation
      in_sel = 2'b11; in_valid = 1'b1; in_data = 16'hDEAD;
      for (int k = 0; k < 100; k++) tick();
      check("t5_drop_100", 32'(drop_cnt), 32'd100);
      for (int k = 0; k < 200; k++) tick();
      in_valid = 1'b0;
      check("t5_drop_sat", 32'(drop_cnt), 32'd255);
      check("t5_out_valid", 32'(out_valid), 32'h0);

      // Async reset mid-cycle with ch0 and ch2 populated
      in_valid = 1'b1;
      in_sel = 2'b00; in_data = 16'h1111;
      tick();
      in_data = 16'h2222;
      tick();
      in_sel = 2'b10; in_data = 16'h3333;
      tick();
      in_valid = 1'b0;
      #1;
      check("t6_pre_valid", 32'(out_valid), 32'h5);
      check("t6_pre_data2", 32'(out_data2), 32'h3333);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(out_valid), 32'h0);
      check("t6_rst_data0", 32'(out_data0), 32'h0);
      check("t6_rst_data2", 32'(out_data2), 32'h0);
      check("t6_rst_drop", 32'(drop_cnt), 32'h0);
      in_sel = 2'b00;
      #1;
      check("t6_rst_ready0", 32'(in_ready), 32'h1);
      rst_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
